uart_rx_sequencer: RTL
======================

# uart_rx_sequencer

Frame-level controller for the UART receive path. Watches the idle line for a start edge and confirms it at mid-bit. Enables the bit-sampling receiver datapath for exactly one frame with a latched baud selection, then captures its data/parity/framing result into a small byte FIFO read by the host side. It sits between the line synchronizer/baud generator and the host bus, and is the only block that drives the receiver's enable and baud select.

## Interface
- FIFO_DEPTH, 4: entries in byte FIFO, power of two, 2..16
- SAMPLES_PER_BIT, 16: sample ticks per bit
- FRAME_BITS, 11: start + 8 data + parity + stop
- TIMEOUT_SLACK, 8: extra ticks beyond FRAME_BITS*SAMPLES_PER_BIT before abort

Ports:
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where reset=1
- cfg_enable  in  1  receiver enable from host
- cfg_baud_sel  in  3  requested baud select code
- rxd_sync  in  1  already-synchronized serial line, idle high
- sample_tick  in  1  one-cycle pulse at SAMPLES_PER_BIT × baud
- rx_valid  in  1  datapath: frame complete, stop bit good
- rx_perror  in  1  datapath parity error, valid with rx_valid/rx_ferror
- rx_ferror  in  1  datapath framing error
- rx_data  in  8  datapath received byte
- rx_en  out  1  enable to receiver datapath and its baud generator
- rx_baud_select  out  3  latched baud code to datapath
- pop  in  1  host read strobe
- dout  out  8  FIFO head byte
- dout_perr  out  1  head entry parity error flag
- dout_ferr  out  1  head entry framing error flag
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- overflow  out  1  sticky: frame dropped because FIFO was full
- timeout  out  1  one-cycle pulse: frame aborted by timeout

## Operation
- States: DISABLED, IDLE, ARMED, RECEIVE, CAPTURE.
- DISABLED: rx_en=0. Goes to IDLE when cfg_enable=1. Clears overflow while cfg_enable=0.
- IDLE: latches rx_baud_select ← cfg_baud_sel every cycle. A falling edge on rxd_sync (previous 1, current 0) goes to ARMED and clears tick_cnt.
- ARMED: counts sample_tick. If rxd_sync=1 on any tick before SAMPLES_PER_BIT/2 ticks, the event is a glitch: return to IDLE. If rxd_sync=0 at tick SAMPLES_PER_BIT/2, go to RECEIVE with rx_en=1 and frame_cnt cleared.
- RECEIVE: rx_en=1, baud select frozen. frame_cnt counts sample_tick.
  - rx_valid or rx_ferror goes to CAPTURE.
  - frame_cnt reaching FRAME_BITS*SAMPLES_PER_BIT+TIMEOUT_SLACK pulses timeout, pushes nothing, and returns to IDLE.
- CAPTURE (one cycle): rx_en=0. Pushes {rx_ferror, rx_perror, rx_data}, registered on the terminating cycle, if not full; otherwise drops the frame and sets overflow. Returns to IDLE.
- cfg_enable=0 in any state goes to DISABLED on the next edge. Any frame in progress is discarded without a push. FIFO contents are retained.
- FIFO: first-word fall-through. dout/dout_perr/dout_ferr show the head when !empty and are 0 when empty. pop while empty is ignored.
- A pop and a push on the same edge are both performed. When full, the push succeeds because the pop frees a slot first, and overflow is not set.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. full and empty are derived from the MSB-differing compare.

## Timing
- Reset values: state=DISABLED, rx_en=0, rx_baud_select=0, empty=1, full=0, overflow=0, timeout=0, dout=0, dout_perr=0, dout_ferr=0, pointers=0.
- Start edge to rx_en high: SAMPLES_PER_BIT/2 sample ticks plus 1 clk.
- rx_valid/rx_ferror to push: 2 clk (RECEIVE→CAPTURE, CAPTURE edge). empty falls on that same edge.
- pop to next head visible on dout: 1 clk.
- timeout is asserted for exactly 1 clk. overflow stays high until reset or cfg_enable=0.
- cfg_baud_sel changes during ARMED/RECEIVE/CAPTURE take effect only from the next IDLE.
- rx_valid together with rx_ferror in the same cycle: treated as a framing error, with ferr=1 pushed.

## Structure
- Shared package uart_pkg:
  - state encoding constants
  - baud select codes (3-bit)
  - UART_FRAME_BITS=11
  - UART_SAMPLES_PER_BIT=16
- Sub-module uart_rx_fifo: parameterized FWFT FIFO, 10-bit wide (ferr, perr, data), with push/pop/full/empty.
- Sequencer FSM and counters live in uart_rx_sequencer.

## Test plan
- Reset asserted mid-RECEIVE -> next edge: rx_en=0, empty=1, overflow=0, state DISABLED. Then cfg_enable=1 with a clean frame 0xA5, good parity -> dout=0xA5, perr=0, ferr=0, empty=0, 2 clk after rx_valid.
- Low glitch of 3 sample ticks on rxd_sync in IDLE -> rx_en never asserts, no push.
- Five frames 0x01..0x05 with no pop, FIFO_DEPTH=4 -> full=1, overflow=1. Pops return 0x01..0x04, then empty=1.
- FIFO full plus pop on the exact CAPTURE cycle of frame 0x77 -> no overflow. Entry 0x77 present and full stays 1.
- rx_en raised but datapath silent -> timeout pulses once at tick 184, state IDLE, FIFO unchanged.
- rx_ferror=1 with rx_perror=1, data 0x3C -> entry {ferr=1, perr=1, 0x3C}. cfg_baud_sel changed mid-frame appears on rx_baud_select only after return to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: sequencer state encoding,
// baud select codes, frame geometry and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_RECEIVE  = 3'd3,
    ST_CAPTURE  = 3'd4
  } rx_state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  localparam int UART_FRAME_BITS      = 11;
  localparam int UART_SAMPLES_PER_BIT = 16;
  localparam int UART_ENTRY_W         = 10;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO for received frames; head reads as zero
// when empty, and a pop on a full FIFO frees the slot for a same-edge push.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted operations and fall-through head
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem[rd_ptr[AW-1:0]];
    end
  end

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Frame-level UART receive controller: start-bit qualification, one-frame
// datapath enable with frozen baud select, timeout abort and result capture.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int SAMPLES_PER_BIT = UART_SAMPLES_PER_BIT,
  parameter int FRAME_BITS      = UART_FRAME_BITS,
  parameter int TIMEOUT_SLACK   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_enable,
  input  logic [2:0] cfg_baud_sel,
  input  logic       rxd_sync,
  input  logic       sample_tick,
  input  logic       rx_valid,
  input  logic       rx_perror,
  input  logic       rx_ferror,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic [2:0] rx_baud_select,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       dout_perr,
  output logic       dout_ferr,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       timeout
);

  localparam int TIMEOUT_TICKS = FRAME_BITS * SAMPLES_PER_BIT + TIMEOUT_SLACK;
  localparam int CNT_W         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] HALF_BIT      = CNT_W'(SAMPLES_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  rx_state_t        state;
  logic             rxd_prev;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] frame_cnt;
  rx_entry_t        cap_entry;
  rx_entry_t        head;
  logic             push;

  // A capture is discarded if the host disables the receiver in that cycle
  always_comb begin
    push      = (state == ST_CAPTURE) && cfg_enable;
    dout      = head.data;
    dout_perr = head.perr;
    dout_ferr = head.ferr;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cap_entry),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  // Sequencer FSM with its counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_DISABLED;
      rx_en          <= 1'b0;
      rx_baud_select <= 3'd0;
      rxd_prev       <= 1'b1;
      tick_cnt       <= {CNT_W{1'b0}};
      frame_cnt      <= {CNT_W{1'b0}};
      cap_entry      <= '{ferr: 1'b0, perr: 1'b0, data: 8'h00};
      overflow       <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      rxd_prev <= rxd_sync;
      timeout  <= 1'b0;
      if (!cfg_enable) begin
        state    <= ST_DISABLED;
        rx_en    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_DISABLED: state <= ST_IDLE;
          ST_IDLE: begin
            rx_baud_select <= cfg_baud_sel;
            if (rxd_prev && !rxd_sync) begin
              state    <= ST_ARMED;
              tick_cnt <= {CNT_W{1'b0}};
            end
          end
          ST_ARMED: begin
            // Line must stay low on every tick up to mid-start-bit
            if (sample_tick) begin
              tick_cnt <= tick_cnt + CNT_ONE;
              if (rxd_sync) begin
                state <= ST_IDLE;
              end else if ((tick_cnt + CNT_ONE) == HALF_BIT) begin
                state     <= ST_RECEIVE;
                rx_en     <= 1'b1;
                frame_cnt <= {CNT_W{1'b0}};
              end
            end
          end
          ST_RECEIVE: begin
            if (rx_valid || rx_ferror) begin
              state     <= ST_CAPTURE;
              rx_en     <= 1'b0;
              cap_entry <= '{ferr: rx_ferror, perr: rx_perror, data: rx_data};
            end else if (sample_tick) begin
              frame_cnt <= frame_cnt + CNT_ONE;
              if ((frame_cnt + CNT_ONE) == TIMEOUT_LIMIT) begin
                timeout <= 1'b1;
                rx_en   <= 1'b0;
                state   <= ST_IDLE;
              end
            end
          end
          ST_CAPTURE: begin
            // A same-edge pop makes room, so only an unrelieved full drops
            if (full && !pop) begin
              overflow <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_DISABLED;
            rx_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
